// File: rtl/rst_seq_ecp5.sv
// -----------------------------------------------------------------------------
// rst_seq_ecp5 -- power-on / button reset sequencer
//
// Purpose:
//   Synchronizes the PLL lock flag and a bouncing reset button into clk_sys,
//   debounces the button, and steps through HOLD -> WAIT -> PERIPH -> RUN.
//   The peripheral reset is released first. The core reset follows later.
//   Any loss of lock, or an accepted button press, drops both resets at once.
//
// Ports:
//   clk_sys       in   system clock (the only clock)
//   rst_sys_n     in   synchronous active-low reset
//   pll_locked    in   PLL lock, asynchronous to clk_sys
//   ext_reset_n   in   board button, active-low, asynchronous, bouncing
//   cause_clr     in   clear sticky reset_cause (RST_SEQ_CAUSE_EN only)
//   rst_periph_n  out  registered active-low peripheral/bus reset
//   rst_core_n    out  registered active-low CPU core reset
//   seq_state     out  HOLD=0, WAIT=1, PERIPH=2, RUN=3
//   reset_cause   out  sticky {button, lock} cause of the last RUN exit
//                      (RST_SEQ_CAUSE_EN only)
//
// Optional feature macro: RST_SEQ_CAUSE_EN
// -----------------------------------------------------------------------------
module rst_seq_ecp5 #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int PERIPH_DELAY    = 16,
  parameter int CORE_DELAY      = 16
) (
  input  logic       clk_sys,
  input  logic       rst_sys_n,
  input  logic       pll_locked,
  input  logic       ext_reset_n,
`ifdef RST_SEQ_CAUSE_EN
  input  logic       cause_clr,
  output logic [1:0] reset_cause,
`endif
  output logic       rst_periph_n,
  output logic       rst_core_n,
  output logic [1:0] seq_state
);

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_PERIPH = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  // The delay counter is shared by WAIT and PERIPH. It is sized for the longer delay.
  localparam int DLY_MAX = (PERIPH_DELAY > CORE_DELAY) ? PERIPH_DELAY : CORE_DELAY;
  localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
  localparam logic [DLY_W-1:0] PD_LAST = DLY_W'(PERIPH_DELAY - 1);
  localparam logic [DLY_W-1:0] CD_LAST = DLY_W'(CORE_DELAY - 1);
  localparam logic [DLY_W-1:0] DLY_ONE = DLY_W'(1);

  logic [SYNC_STAGES-1:0] r_lock_sync;
  logic [SYNC_STAGES-1:0] r_btn_sync;
  logic                   w_locked_s;
  logic                   w_btn_s;

  logic                   r_btn_db;
  logic [DB_W-1:0]        r_db_cnt;

  logic                   w_fault;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [DLY_W-1:0]       r_dly;
  logic [DLY_W-1:0]       w_dly_nxt;

  logic                   r_periph_n;
  logic                   r_core_n;
  logic                   w_periph_n_nxt;
  logic                   w_core_n_nxt;

  assign w_locked_s = r_lock_sync[SYNC_STAGES-1];
  assign w_btn_s    = r_btn_sync[SYNC_STAGES-1];
  assign w_fault    = !w_locked_s || !r_btn_db;

  // Synchronizer chains for the two asynchronous inputs
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      r_lock_sync <= {SYNC_STAGES{1'b0}};
      r_btn_sync  <= {SYNC_STAGES{1'b0}};
    end else begin
      r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], pll_locked};
      r_btn_sync  <= {r_btn_sync[SYNC_STAGES-2:0], ext_reset_n};
    end
  end

  // Button debounce: accept a new level only after it has been stable for long enough
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      r_btn_db <= 1'b0;
      r_db_cnt <= {DB_W{1'b0}};
    end else if (w_btn_s == r_btn_db) begin
      r_db_cnt <= {DB_W{1'b0}};
    end else if (r_db_cnt == DB_LAST) begin
      r_btn_db <= w_btn_s;
      r_db_cnt <= {DB_W{1'b0}};
    end else begin
      r_db_cnt <= r_db_cnt + DB_ONE;
    end
  end

  // Sequencer state register and shared delay counter
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      r_state <= ST_HOLD;
      r_dly   <= {DLY_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_dly   <= w_dly_nxt;
    end
  end

  // Next-state logic; a fault overrides every other transition
  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = {DLY_W{1'b0}};
    if (w_fault) begin
      w_state_nxt = ST_HOLD;
      w_dly_nxt   = {DLY_W{1'b0}};
    end else begin
      case (r_state)
        ST_HOLD: begin
          w_state_nxt = ST_WAIT;
          w_dly_nxt   = {DLY_W{1'b0}};
        end
        ST_WAIT: begin
          if (r_dly == PD_LAST) begin
            w_state_nxt = ST_PERIPH;
            w_dly_nxt   = {DLY_W{1'b0}};
          end else begin
            w_state_nxt = ST_WAIT;
            w_dly_nxt   = r_dly + DLY_ONE;
          end
        end
        ST_PERIPH: begin
          if (r_dly == CD_LAST) begin
            w_state_nxt = ST_RUN;
            w_dly_nxt   = {DLY_W{1'b0}};
          end else begin
            w_state_nxt = ST_PERIPH;
            w_dly_nxt   = r_dly + DLY_ONE;
          end
        end
        ST_RUN: begin
          w_state_nxt = ST_RUN;
          w_dly_nxt   = {DLY_W{1'b0}};
        end
        default: begin
          w_state_nxt = ST_HOLD;
          w_dly_nxt   = {DLY_W{1'b0}};
        end
      endcase
    end
  end

  // Output decode from the next state, so the registered resets move on the same edge as r_state
  always_comb begin
    w_periph_n_nxt = 1'b0;
    w_core_n_nxt   = 1'b0;
    case (w_state_nxt)
      ST_HOLD:   begin w_periph_n_nxt = 1'b0; w_core_n_nxt = 1'b0; end
      ST_WAIT:   begin w_periph_n_nxt = 1'b0; w_core_n_nxt = 1'b0; end
      ST_PERIPH: begin w_periph_n_nxt = 1'b1; w_core_n_nxt = 1'b0; end
      ST_RUN:    begin w_periph_n_nxt = 1'b1; w_core_n_nxt = 1'b1; end
      default:   begin w_periph_n_nxt = 1'b0; w_core_n_nxt = 1'b0; end
    endcase
  end

  // Registered reset outputs
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      r_periph_n <= 1'b0;
      r_core_n   <= 1'b0;
    end else begin
      r_periph_n <= w_periph_n_nxt;
      r_core_n   <= w_core_n_nxt;
    end
  end

  assign rst_periph_n = r_periph_n;
  assign rst_core_n   = r_core_n;
  assign seq_state    = r_state;

`ifdef RST_SEQ_CAUSE_EN
  logic [1:0] r_cause;
  logic [1:0] w_cause_set;

  // Record why RUN was left: bit1 = button, bit0 = lock loss
  always_comb begin
    w_cause_set = 2'b00;
    if ((r_state == ST_RUN) && w_fault) begin
      w_cause_set = {!r_btn_db, !w_locked_s};
    end else begin
      w_cause_set = 2'b00;
    end
  end

  // Sticky cause register; a new cause on the clearing edge wins over the clear
  always_ff @(posedge clk_sys) begin
    if (!rst_sys_n) begin
      r_cause <= 2'b00;
    end else begin
      r_cause <= (cause_clr ? 2'b00 : r_cause) | w_cause_set;
    end
  end

  assign reset_cause = r_cause;
`endif

endmodule
